// File: rtl/bubsys_sdram_arbiter.sv
// SDRAM access arbiter: ROM download writes take priority over two
// round-robin read ports; one access in flight at a time.
module bubsys_sdram_arbiter #(
   parameter int unsigned AW = 22
) (
   input  logic          i_EMU_MCLK,
   input  logic          i_EMU_RST_n,
   // ROM download
   input  logic          i_DL_EN,
   input  logic          i_DL_WR,
   input  logic [AW:0]   i_DL_ADDR,
   input  logic [7:0]    i_DL_DATA,
   output logic          o_DL_WAIT,
   // read port A (main CPU)
   input  logic          i_RDA_REQ,
   input  logic [AW-1:0] i_RDA_ADDR,
   output logic [15:0]   o_RDA_DATA,
   output logic          o_RDA_ACK,
   // read port B (video/sound)
   input  logic          i_RDB_REQ,
   input  logic [AW-1:0] i_RDB_ADDR,
   output logic [15:0]   o_RDB_DATA,
   output logic          o_RDB_ACK,
   // memory controller
   output logic          o_MEM_REQ,
   output logic          o_MEM_WE,
   output logic [AW-1:0] o_MEM_ADDR,
   output logic [15:0]   o_MEM_DIN,
   input  logic [15:0]   i_MEM_DOUT,
   input  logic          i_MEM_ACK
);

   typedef enum logic [2:0] {StIdle, StDlWrite, StRdA, StRdB, StFlush} state_e;

   state_e        state_q, state_d;

   logic          dl_en_q;
   logic          lo_held_q;
   logic          word_pend_q;
   logic          flush_pend_q;
   logic          dl_wait_q;
   logic          rr_b_q;        // 1: B wins the next A/B tie
   logic [7:0]    lo_byte_q;
   logic [7:0]    hi_byte_q;
   logic [AW-1:0] lo_addr_q;
   logic [AW-1:0] word_addr_q;
   logic          mem_req_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [15:0]   mem_din_q;
   logic [15:0]   rda_data_q;
   logic [15:0]   rdb_data_q;
   logic          rda_ack_q;
   logic          rdb_ack_q;

   logic          dl_strobe;
   logic          mem_ack;
   logic          req_a;
   logic          req_b;
   logic          read_ok;
   logic          grant_dl;
   logic          grant_flush;
   logic          grant_a;
   logic          grant_b;

   // Strobes during a stall are dropped, not queued.
   assign dl_strobe = i_DL_EN & i_DL_WR & ~dl_wait_q;
   assign mem_ack   = i_MEM_ACK & mem_req_q;
   // A request still high in its own ACK cycle belongs to the finished access.
   assign req_a     = i_RDA_REQ & ~rda_ack_q;
   assign req_b     = i_RDB_REQ & ~rdb_ack_q;
   // dl_en_q covers the cycle where a tail flush is about to be flagged.
   assign read_ok   = ~i_DL_EN & ~dl_en_q & ~word_pend_q & ~flush_pend_q;

   assign o_DL_WAIT  = dl_wait_q;
   assign o_RDA_DATA = rda_data_q;
   assign o_RDA_ACK  = rda_ack_q;
   assign o_RDB_DATA = rdb_data_q;
   assign o_RDB_ACK  = rdb_ack_q;
   assign o_MEM_REQ  = mem_req_q;
   assign o_MEM_WE   = mem_we_q;
   assign o_MEM_ADDR = mem_addr_q;
   assign o_MEM_DIN  = mem_din_q;

   // State register.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant selection in idle; every access state returns to idle on its ACK.
   always_comb begin
      state_d     = state_q;
      grant_dl    = 1'b0;
      grant_flush = 1'b0;
      grant_a     = 1'b0;
      grant_b     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (word_pend_q) begin
               grant_dl = 1'b1;
               state_d  = StDlWrite;
            end else if (flush_pend_q) begin
               grant_flush = 1'b1;
               state_d     = StFlush;
            end else if (read_ok && req_a && (!req_b || !rr_b_q)) begin
               grant_a = 1'b1;
               state_d = StRdA;
            end else if (read_ok && req_b) begin
               grant_b = 1'b1;
               state_d = StRdB;
            end
         end
         StDlWrite, StRdA, StRdB, StFlush: begin
            if (mem_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Download byte packing, memory request registers and read returns.
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         dl_en_q      <= 1'b0;
         lo_held_q    <= 1'b0;
         word_pend_q  <= 1'b0;
         flush_pend_q <= 1'b0;
         dl_wait_q    <= 1'b0;
         rr_b_q       <= 1'b0;
         lo_byte_q    <= '0;
         hi_byte_q    <= '0;
         lo_addr_q    <= '0;
         word_addr_q  <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         rda_data_q   <= '0;
         rdb_data_q   <= '0;
         rda_ack_q    <= 1'b0;
         rdb_ack_q    <= 1'b0;
      end else begin
         dl_en_q   <= i_DL_EN;
         rda_ack_q <= 1'b0;
         rdb_ack_q <= 1'b0;

         if (dl_strobe && !i_DL_ADDR[0]) begin
            lo_byte_q <= i_DL_DATA;
            lo_addr_q <= i_DL_ADDR[AW:1];
            lo_held_q <= 1'b1;
         end
         if (dl_strobe && i_DL_ADDR[0]) begin
            hi_byte_q   <= i_DL_DATA;
            word_addr_q <= i_DL_ADDR[AW:1];
            word_pend_q <= 1'b1;
            lo_held_q   <= 1'b0;
            dl_wait_q   <= 1'b1;
         end
         // Download ended with an unpaired even byte: write it zero-extended.
         if (dl_en_q && !i_DL_EN && lo_held_q) begin
            flush_pend_q <= 1'b1;
            lo_held_q    <= 1'b0;
         end

         if (grant_dl) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= word_addr_q;
            mem_din_q  <= {hi_byte_q, lo_byte_q};
         end
         if (grant_flush) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= lo_addr_q;
            mem_din_q  <= {8'h00, lo_byte_q};
         end
         if (grant_a) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_RDA_ADDR;
            rr_b_q     <= 1'b1;
         end
         if (grant_b) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_RDB_ADDR;
            rr_b_q     <= 1'b0;
         end

         if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            case (state_q)
               StDlWrite: begin
                  word_pend_q <= 1'b0;
                  dl_wait_q   <= 1'b0;
               end
               StFlush: flush_pend_q <= 1'b0;
               StRdA: begin
                  rda_data_q <= i_MEM_DOUT;
                  rda_ack_q  <= 1'b1;
               end
               StRdB: begin
                  rdb_data_q <= i_MEM_DOUT;
                  rdb_ack_q  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bubsys_sdram_arbiter.sv
// Self-checking bench: memory model with fixed latency, scoreboard of
// expected memory accesses and read returns, scenario tasks in sequence.
module tb_bubsys_sdram_arbiter;

   localparam int unsigned AW = 22;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          dl_en = 1'b0;
   logic          dl_wr = 1'b0;
   logic [AW:0]   dl_addr = '0;
   logic [7:0]    dl_data = '0;
   logic          dl_wait;
   logic          rda_req = 1'b0;
   logic [AW-1:0] rda_addr = '0;
   logic [15:0]   rda_data;
   logic          rda_ack;
   logic          rdb_req = 1'b0;
   logic [AW-1:0] rdb_addr = '0;
   logic [15:0]   rdb_data;
   logic          rdb_ack;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_din;
   logic [15:0]   mem_dout = '0;
   logic          mem_ack = 1'b0;

   int checks = 0;
   int errors = 0;
   int rda_acks = 0;
   bit mem_auto = 1'b0;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [15:0]   din;
   } acc_t;
   typedef struct {
      logic        port;   // 0: A, 1: B
      logic [15:0] data;
   } rd_t;

   acc_t acc_q[$];
   rd_t  rd_q[$];

   bubsys_sdram_arbiter #(.AW(AW)) dut (
      .i_EMU_MCLK (clk),
      .i_EMU_RST_n(rst_n),
      .i_DL_EN    (dl_en),
      .i_DL_WR    (dl_wr),
      .i_DL_ADDR  (dl_addr),
      .i_DL_DATA  (dl_data),
      .o_DL_WAIT  (dl_wait),
      .i_RDA_REQ  (rda_req),
      .i_RDA_ADDR (rda_addr),
      .o_RDA_DATA (rda_data),
      .o_RDA_ACK  (rda_ack),
      .i_RDB_REQ  (rdb_req),
      .i_RDB_ADDR (rdb_addr),
      .o_RDB_DATA (rdb_data),
      .o_RDB_ACK  (rdb_ack),
      .o_MEM_REQ  (mem_req),
      .o_MEM_WE   (mem_we),
      .o_MEM_ADDR (mem_addr),
      .o_MEM_DIN  (mem_din),
      .i_MEM_DOUT (mem_dout),
      .i_MEM_ACK  (mem_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_data(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_acc(input logic we, input logic [AW-1:0] a, input logic [15:0] d);
      acc_t e;
      e.we = we; e.addr = a; e.din = d;
      acc_q.push_back(e);
   endtask

   task automatic push_rd(input logic p, input logic [15:0] d);
      rd_t e;
      e.port = p; e.data = d;
      rd_q.push_back(e);
   endtask

   task automatic dl_byte(input logic [AW:0] a, input logic [7:0] d);
      dl_wr = 1'b1; dl_addr = a; dl_data = d;
      tick();
      dl_wr = 1'b0;
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (acc_q.size() == 0 && rd_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Memory controller model: acks on the third cycle of a request.
   initial begin : mem_model
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!mem_auto) cnt = 0;
         else if (mem_ack) begin
            mem_ack = 1'b0;
            cnt     = 0;
         end else if (mem_req) begin
            cnt++;
            if (cnt == 3) begin
               mem_ack  = 1'b1;
               mem_dout = model_data(mem_addr);
            end
         end else cnt = 0;
      end
   end

   // Scoreboard: compare each completed access and each read return.
   initial begin : monitor
      bit prev_a, prev_b;
      prev_a = 1'b0;
      prev_b = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_ack && mem_req) begin
            checks++;
            if (acc_q.size() == 0) begin
               errors++;
               $display("FAIL acc_unexpected: got we=%0b addr=%h din=%h, required none",
                        mem_we, mem_addr, mem_din);
            end else begin
               acc_t e;
               e = acc_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_din !== e.din)) begin
                  errors++;
                  $display("FAIL acc: got we=%0b addr=%h din=%h, required we=%0b addr=%h din=%h",
                           mem_we, mem_addr, mem_din, e.we, e.addr, e.din);
               end
            end
         end
         if (rda_ack || rdb_ack) begin
            checks++;
            if ((rda_ack && prev_a) || (rdb_ack && prev_b) || (rda_ack && rdb_ack)) begin
               errors++;
               $display("FAIL ack_pulse: got a=%0b b=%0b prev_a=%0b prev_b=%0b, required 1-cycle",
                        rda_ack, rdb_ack, prev_a, prev_b);
            end
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected: got a=%0b b=%0b, required none", rda_ack, rdb_ack);
            end else begin
               rd_t e;
               e = rd_q.pop_front();
               if (rda_ack && (e.port !== 1'b0 || rda_data !== e.data)) begin
                  errors++;
                  $display("FAIL rd_a: got port A data=%h, required port %0d data=%h",
                           rda_data, e.port, e.data);
               end
               if (rdb_ack && (e.port !== 1'b1 || rdb_data !== e.data)) begin
                  errors++;
                  $display("FAIL rd_b: got port B data=%h, required port %0d data=%h",
                           rdb_data, e.port, e.data);
               end
            end
         end
         if (rda_ack) rda_acks++;
         prev_a = rda_ack;
         prev_b = rdb_ack;
      end
   end

   task automatic test_reset();
      #2;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, dl_wait, rda_ack, rdb_ack} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 00000",
                  {mem_req, mem_we, dl_wait, rda_ack, rdb_ack});
      end
      checks++;
      if (mem_addr !== '0 || mem_din !== '0) begin
         errors++;
         $display("FAIL reset_mem: got addr=%h din=%h, required 0", mem_addr, mem_din);
      end
      checks++;
      if (rda_data !== '0 || rdb_data !== '0) begin
         errors++;
         $display("FAIL reset_data: got a=%h b=%h, required 0", rda_data, rdb_data);
      end
      rst_n = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_round_robin();
      int n;
      bit ok;
      rda_addr = 22'h100;
      rdb_addr = 22'h200;
      for (int i = 0; i < 2; i++) begin
         push_acc(1'b0, 22'h100, 16'h0); push_rd(1'b0, model_data(22'h100));
         push_acc(1'b0, 22'h200, 16'h0); push_rd(1'b1, model_data(22'h200));
      end
      mem_auto = 1'b1;
      rda_req = 1'b1;
      rdb_req = 1'b1;
      n = 0;
      for (int i = 0; i < 200 && n < 4; i++) begin
         @(negedge clk);
         if (rda_ack || rdb_ack) n++;
         if (n == 3 && rda_req) begin
            @(posedge clk); #1; rda_req = 1'b0;
         end
         if (n == 4) begin
            @(posedge clk); #1; rdb_req = 1'b0;
         end
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL rr_count: got %0d acks, required 4", n);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rr_drain: got %0d/%0d outstanding, required 0", acc_q.size(), rd_q.size());
      end
   endtask

   task automatic test_dl_word();
      int n;
      bit ok;
      dl_en = 1'b1;
      tick();
      push_acc(1'b1, 22'h0, 16'h3412);
      dl_byte(23'h0, 8'h12);
      dl_byte(23'h1, 8'h34);
      @(negedge clk);
      checks++;
      if (dl_wait !== 1'b1) begin
         errors++;
         $display("FAIL dl_wait_rise: got %b, required 1", dl_wait);
      end
      n = 0;
      while (!(mem_ack && mem_req) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!(mem_ack && mem_req) || dl_wait !== 1'b1) begin
         errors++;
         $display("FAIL dl_wait_at_ack: got ack=%b wait=%b, required ack=1 wait=1",
                  mem_ack && mem_req, dl_wait);
      end
      @(negedge clk);
      checks++;
      if (dl_wait !== 1'b0) begin
         errors++;
         $display("FAIL dl_wait_fall: got %b, required 0", dl_wait);
      end
      dl_en = 1'b0;
      wait_drain(ok);
      repeat (5) @(negedge clk);
      checks++;
      if (!ok || acc_q.size() != 0) begin
         errors++;
         $display("FAIL dl_word_drain: got %0d outstanding, required 0", acc_q.size());
      end
   endtask

   task automatic test_dl_flush();
      int n;
      int snap;
      bit ok;
      push_acc(1'b1, 22'h0, 16'hBBAA);
      push_acc(1'b1, 22'h1, 16'h00CC);
      push_acc(1'b0, 22'h123, 16'h0);
      push_rd(1'b0, model_data(22'h123));
      snap = rda_acks;
      rda_addr = 22'h123;
      rda_req = 1'b1;
      dl_en = 1'b1;
      tick();
      dl_byte(23'h0, 8'hAA);
      dl_byte(23'h1, 8'hBB);
      n = 0;
      while (dl_wait && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (dl_wait !== 1'b0) begin
         errors++;
         $display("FAIL flush_wait_release: got %b, required 0", dl_wait);
      end
      dl_byte(23'h2, 8'hCC);
      dl_en = 1'b0;
      n = 0;
      while (acc_q.size() > 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (acc_q.size() != 1 || rda_acks != snap) begin
         errors++;
         $display("FAIL flush_before_read: got %0d left, %0d A acks, required 1 left, 0 A acks",
                  acc_q.size(), rda_acks - snap);
      end
      n = 0;
      while (!rda_ack && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1; rda_req = 1'b0;
      wait_drain(ok);
      checks++;
      if (!ok || rda_acks != snap + 1) begin
         errors++;
         $display("FAIL flush_read: got %0d A acks, required 1", rda_acks - snap);
      end
   endtask

   task automatic test_spurious_ack();
      int n;
      bit ok;
      mem_auto = 1'b0;
      tick();
      mem_dout = 16'hDEAD;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (rda_ack || rdb_ack || mem_req) begin
            errors++;
            $display("FAIL spurious_out: got a=%b b=%b req=%b, required 0", rda_ack, rdb_ack,
                     mem_req);
         end
      end
      checks++;
      if (rda_data !== model_data(22'h123) || rdb_data !== model_data(22'h200)) begin
         errors++;
         $display("FAIL spurious_data: got a=%h b=%h, required a=%h b=%h", rda_data, rdb_data,
                  model_data(22'h123), model_data(22'h200));
      end
      mem_auto = 1'b1;
      push_acc(1'b0, 22'h055, 16'h0);
      push_rd(1'b0, model_data(22'h055));
      rda_addr = 22'h055;
      rda_req = 1'b1;
      n = 0;
      while (!rda_ack && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1; rda_req = 1'b0;
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL spurious_then_read: got %0d/%0d outstanding, required 0",
                  acc_q.size(), rd_q.size());
      end
   endtask

   task automatic test_reset_mid_access();
      int n;
      bit ok;
      mem_auto = 1'b0;
      rda_addr = 22'h300;
      rdb_addr = 22'h400;
      rda_req = 1'b1;
      rdb_req = 1'b1;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 22'h400) begin
         errors++;
         $display("FAIL pre_reset_grant: got req=%b addr=%h, required req=1 addr=400",
                  mem_req, mem_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_we, dl_wait, rda_ack, rdb_ack} !== 5'b0 || mem_addr !== '0 ||
          mem_din !== '0 || rda_data !== '0 || rdb_data !== '0) begin
         errors++;
         $display("FAIL async_reset: got ctrl=%b addr=%h din=%h a=%h b=%h, required all 0",
                  {mem_req, mem_we, dl_wait, rda_ack, rdb_ack}, mem_addr, mem_din,
                  rda_data, rdb_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      push_acc(1'b0, 22'h300, 16'h0); push_rd(1'b0, model_data(22'h300));
      push_acc(1'b0, 22'h400, 16'h0); push_rd(1'b1, model_data(22'h400));
      mem_auto = 1'b1;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 22'h300) begin
         errors++;
         $display("FAIL post_reset_grant: got req=%b addr=%h, required req=1 addr=300",
                  mem_req, mem_addr);
      end
      for (int i = 0; i < 100 && rdb_req; i++) begin
         @(negedge clk);
         if (rda_ack) begin
            @(posedge clk); #1; rda_req = 1'b0;
         end else if (rdb_ack) begin
            @(posedge clk); #1; rdb_req = 1'b0;
         end
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL post_reset_drain: got %0d/%0d outstanding, required 0",
                  acc_q.size(), rd_q.size());
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

   initial begin : main
      test_reset();
      test_round_robin();
      test_dl_word();
      test_dl_flush();
      test_spurious_ack();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/bubsys_sdram_arbiter.md
BUBSYS_SDRAM_ARBITER -- requirements
Module: bubsys_sdram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 22, the SDRAM word-address width.
REQ-002 SHALL have port i_EMU_MCLK, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port i_EMU_RST_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have these download ports:
- i_DL_EN, input, 1: ROM download active.
- i_DL_WR, input, 1: byte strobe.
- i_DL_ADDR, input, AW+1: byte address.
- i_DL_DATA, input, 8: byte.
- o_DL_WAIT, output, 1: download stall.
REQ-005 SHALL have these read-port-A ports (main CPU):
- i_RDA_REQ, input, 1: level request.
- i_RDA_ADDR, input, AW: word address.
- o_RDA_DATA, output, 16: read data.
- o_RDA_ACK, output, 1: completion pulse.
REQ-006 SHALL have read-port-B ports (video/sound) identical to REQ-005 with the RDB prefix.
REQ-007 SHALL have these memory-controller ports:
- o_MEM_REQ, output, 1: access request.
- o_MEM_WE, output, 1: write.
- o_MEM_ADDR, output, AW: word address.
- o_MEM_DIN, output, 16: write data.
- i_MEM_DOUT, input, 16: read data.
- i_MEM_ACK, input, 1: one-cycle completion; i_MEM_DOUT is valid in that same cycle.

Function
REQ-008 SHALL implement an FSM with states IDLE, DL_WRITE, RD_A, RD_B and FLUSH.
REQ-009 SHALL, in IDLE, choose the next grant with this priority: pending download word, then pending tail flush, then reads.
REQ-010 SHALL serve no read while i_DL_EN=1; read requests stay pending and unacknowledged until download ends.
REQ-011 SHALL latch i_DL_DATA as the low byte on i_DL_WR when i_DL_ADDR[0]=0, and set a "low byte held" flag.
REQ-012 SHALL, on i_DL_WR when i_DL_ADDR[0]=1, latch the high byte, form word address i_DL_ADDR[AW:1], set "word pending" and clear "low byte held".
REQ-013 SHALL raise o_DL_WAIT (registered) the cycle after the odd-byte strobe and hold it through the cycle of the matching i_MEM_ACK; it falls the cycle after that ACK.
REQ-014 SHALL ignore any i_DL_WR that arrives while o_DL_WAIT=1 (protocol violation; it is not queued).
REQ-015 SHALL, on the falling edge of i_DL_EN with "low byte held", write the word {8'h00, low byte} in state FLUSH before any read is served.
REQ-016 SHALL, when both read ports are pending in IDLE, grant the port not granted last (round-robin pointer); at reset the pointer favours A.
REQ-017 SHALL assert o_MEM_REQ registered, one cycle after the IDLE grant decision, with o_MEM_ADDR, o_MEM_WE and o_MEM_DIN stable until i_MEM_ACK.
REQ-018 SHALL drop o_MEM_REQ the cycle after i_MEM_ACK and return to IDLE; minimum spacing between requests is 2 cycles.
REQ-019 SHALL, on a read i_MEM_ACK, register i_MEM_DOUT into o_RDx_DATA and pulse o_RDx_ACK for exactly 1 cycle, the cycle after i_MEM_ACK.
REQ-020 SHALL hold o_RDx_DATA until that port's next ACK.
REQ-021 SHALL treat a requester that keeps i_RDx_REQ high in the cycle after o_RDx_ACK as making a new request.
REQ-022 SHALL ignore i_MEM_ACK when o_MEM_REQ=0.
REQ-023 SHALL sample a read's address at the grant cycle; later changes to i_RDx_ADDR do not affect the access in flight.
REQ-024 SHALL, when i_DL_EN rises while a read is in flight, complete and acknowledge that read normally before serving download words.

Reset
REQ-025 SHALL, while i_EMU_RST_n=0, hold the FSM in IDLE and drive o_MEM_REQ, o_MEM_WE, o_DL_WAIT, o_RDA_ACK and o_RDB_ACK to 0.
REQ-026 SHALL, while i_EMU_RST_n=0, clear o_MEM_ADDR, o_MEM_DIN, o_RDA_DATA, o_RDB_DATA, all byte latches and flags, and set the round-robin pointer to A.
REQ-027 SHALL, when reset asserts mid-access, abandon the access; the memory controller shares this reset.

Verification
REQ-028 SHALL cover: download bytes 0x12 @0, 0x34 @1 -> one write, ADDR=0, DIN=0x3412, WE=1; o_DL_WAIT high from the cycle after the odd strobe until 1 cycle after ACK.
REQ-029 SHALL cover: 3-byte download 0xAA, 0xBB, 0xCC then i_DL_EN falls -> writes 0xBBAA @0 and 0x00CC @1, the latter before any pending read.
REQ-030 SHALL cover: A and B requesting continuously, memory acking 3 cycles after REQ -> grants alternate A, B, A, B; each ACK is a 1-cycle pulse carrying the matching DOUT.
REQ-031 SHALL cover: i_RDA_REQ held during i_DL_EN=1 -> no o_RDA_ACK until download ends and the flush completes; then the A read completes.
REQ-032 SHALL cover: i_EMU_RST_n pulsed low while o_MEM_REQ=1 -> all outputs 0 within the same cycle (asynchronous); after release the FSM idles and the first grant favours A.
REQ-033 SHALL cover: spurious i_MEM_ACK while idle -> no ACK output and no state change.
